// File: rtl/free_list.sv
// Physical-register free list: circular FIFO of free preg tags feeding rename
// (up to 4 pops per cycle) and refilled from ROB retire (up to 4 pushes per cycle).
module free_list #(
    parameter int PREGS = 64,
    parameter int AREGS = 32,
    parameter int DEPTH = PREGS - AREGS,
    parameter int LANES = 4,
    localparam int TAG_W = $clog2(PREGS),
    localparam int IDX_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [2:0]       i_alloc_count,
    output logic [TAG_W-1:0] o_alloc_p0,
    output logic [TAG_W-1:0] o_alloc_p1,
    output logic [TAG_W-1:0] o_alloc_p2,
    output logic [TAG_W-1:0] o_alloc_p3,
    output logic [CNT_W-1:0] o_free_count,
    output logic             o_alloc_ok,
    input  logic [LANES-1:0] i_free_en,
    input  logic [TAG_W-1:0] i_free_p0,
    input  logic [TAG_W-1:0] i_free_p1,
    input  logic [TAG_W-1:0] i_free_p2,
    input  logic [TAG_W-1:0] i_free_p3,
    output logic             o_underflow,
    output logic             o_overflow
);

    localparam logic [IDX_W:0]   DEPTH_P = (IDX_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   DEPTH_X = (CNT_W + 1)'(DEPTH);

    // Ring index plus offset, reduced modulo DEPTH.
    function automatic logic [IDX_W-1:0] f_idx(input logic [IDX_W-1:0] base,
                                               input logic [2:0]       off);
        logic [IDX_W:0] sum;
        sum = {1'b0, base} + (IDX_W + 1)'(off);
        if (sum >= DEPTH_P) sum = sum - DEPTH_P;
        return sum[IDX_W-1:0];
    endfunction

    // Pointer advance returning {wrap, index}; the wrap bit toggles on crossing DEPTH.
    function automatic logic [IDX_W:0] f_adv(input logic             wrap,
                                             input logic [IDX_W-1:0] base,
                                             input logic [2:0]       off);
        logic [IDX_W:0] sum;
        logic           w;
        sum = {1'b0, base} + (IDX_W + 1)'(off);
        w   = wrap;
        if (sum >= DEPTH_P) begin
            sum = sum - DEPTH_P;
            w   = ~wrap;
        end
        return {w, sum[IDX_W-1:0]};
    endfunction

    logic [TAG_W-1:0] r_mem [DEPTH];
    logic [IDX_W-1:0] r_head;
    logic             r_head_wrap;
    logic [IDX_W-1:0] r_tail;
    logic             r_tail_wrap;
    logic [CNT_W-1:0] r_count;
    logic             r_underflow;
    logic             r_overflow;

    logic [TAG_W-1:0] w_free_tag  [LANES];
    logic [2:0]       w_free_off  [LANES];
    logic [IDX_W-1:0] w_rd_idx    [LANES];
    logic [IDX_W-1:0] w_wr_idx    [LANES];
    logic [2:0]       w_free_num;
    logic             w_alloc_ok;
    logic             w_alloc_acc;
    logic [2:0]       w_pop;
    logic [CNT_W-1:0] w_after_pop;
    logic             w_ovf;
    logic [2:0]       w_push;
    logic [CNT_W-1:0] w_count_nxt;
    logic [IDX_W:0]   w_head_nxt;
    logic [IDX_W:0]   w_tail_nxt;
    logic [CNT_W-1:0] w_occ;

    assign w_free_tag[0] = i_free_p0;
    assign w_free_tag[1] = i_free_p1;
    assign w_free_tag[2] = i_free_p2;
    assign w_free_tag[3] = i_free_p3;

    // Compaction: each set lane lands at tail + (number of set lanes below it).
    always_comb begin
        w_free_num = '0;
        for (int n = 0; n < LANES; n++) begin
            w_free_off[n] = w_free_num;
            w_free_num    = w_free_num + 3'(i_free_en[n]);
        end
    end

    always_comb begin
        for (int n = 0; n < LANES; n++) begin
            w_rd_idx[n] = f_idx(r_head, 3'(n));
            w_wr_idx[n] = f_idx(r_tail, w_free_off[n]);
        end
    end

    // Alloc decides against the registered count only; same-cycle frees are not visible.
    always_comb begin
        w_alloc_ok  = (CNT_W'(i_alloc_count) <= r_count);
        w_alloc_acc = w_alloc_ok && (i_alloc_count <= 3'(LANES));
        w_pop       = w_alloc_acc ? i_alloc_count : 3'd0;
        w_after_pop = r_count - CNT_W'(w_pop);
        w_ovf       = ({1'b0, w_after_pop} + (CNT_W + 1)'(w_free_num)) > DEPTH_X;
        w_push      = w_ovf ? 3'd0 : w_free_num;
        w_count_nxt = w_after_pop + CNT_W'(w_push);
        w_head_nxt  = f_adv(r_head_wrap, r_head, w_pop);
        w_tail_nxt  = f_adv(r_tail_wrap, r_tail, w_push);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= TAG_W'(AREGS + i);
            end
            r_head      <= '0;
            r_head_wrap <= 1'b0;
            r_tail      <= '0;
            r_tail_wrap <= 1'b1;
            r_count     <= DEPTH_C;
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            for (int n = 0; n < LANES; n++) begin
                if (i_free_en[n] && !w_ovf) begin
                    r_mem[w_wr_idx[n]] <= w_free_tag[n];
                end
            end
            r_head      <= w_head_nxt[IDX_W-1:0];
            r_head_wrap <= w_head_nxt[IDX_W];
            r_tail      <= w_tail_nxt[IDX_W-1:0];
            r_tail_wrap <= w_tail_nxt[IDX_W];
            r_count     <= w_count_nxt;
            r_underflow <= ~w_alloc_acc;
            r_overflow  <= w_ovf;
        end
    end

    assign o_alloc_p0   = r_mem[w_rd_idx[0]];
    assign o_alloc_p1   = r_mem[w_rd_idx[1]];
    assign o_alloc_p2   = r_mem[w_rd_idx[2]];
    assign o_alloc_p3   = r_mem[w_rd_idx[3]];
    assign o_free_count = r_count;
    assign o_alloc_ok   = w_alloc_ok;
    assign o_underflow  = r_underflow;
    assign o_overflow   = r_overflow;

    // Occupancy implied by the pointers; equal wrap bits mean tail is ahead in the same lap.
    always_comb begin
        if (r_tail_wrap == r_head_wrap) begin
            w_occ = CNT_W'(r_tail) - CNT_W'(r_head);
        end else begin
            w_occ = DEPTH_C - CNT_W'(r_head) + CNT_W'(r_tail);
        end
    end

    a_count_ptrs: assert property (@(posedge i_clk) disable iff (i_rst) r_count == w_occ);
    a_count_max:  assert property (@(posedge i_clk) disable iff (i_rst) r_count <= DEPTH_C);

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: table of per-cycle vectors with hand-computed
// expectations, plus hand-written reset sequences.
module tb_free_list;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] alloc_count;
    logic [5:0] alloc_p0, alloc_p1, alloc_p2, alloc_p3;
    logic [5:0] free_count;
    logic       alloc_ok;
    logic [3:0] free_en;
    logic [5:0] free_p0, free_p1, free_p2, free_p3;
    logic       underflow, overflow;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    free_list dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_alloc_count(alloc_count),
        .o_alloc_p0   (alloc_p0),
        .o_alloc_p1   (alloc_p1),
        .o_alloc_p2   (alloc_p2),
        .o_alloc_p3   (alloc_p3),
        .o_free_count (free_count),
        .o_alloc_ok   (alloc_ok),
        .i_free_en    (free_en),
        .i_free_p0    (free_p0),
        .i_free_p1    (free_p1),
        .i_free_p2    (free_p2),
        .i_free_p3    (free_p3),
        .o_underflow  (underflow),
        .o_overflow   (overflow)
    );

    typedef struct {
        int ac;
        int en;
        int f0, f1, f2, f3;
        int ok;
        int cnt;
        int uf;
        int of;
        int e0, e1, e2, e3;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int ac, input int en, input int f0, input int f1,
                       input int f2, input int f3, input int ok, input int cnt,
                       input int uf, input int of, input int e0, input int e1,
                       input int e2, input int e3);
        vec_t v;
        v.ac = ac; v.en = en; v.f0 = f0; v.f1 = f1; v.f2 = f2; v.f3 = f3;
        v.ok = ok; v.cnt = cnt; v.uf = uf; v.of = of;
        v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int cnt, input int uf, input int of,
                             input int e0, input int e1, input int e2, input int e3);
        chk({tag, " count"}, 8'(free_count), 8'(cnt));
        chk({tag, " underflow"}, 8'(underflow), 8'(uf));
        chk({tag, " overflow"}, 8'(overflow), 8'(of));
        if (cnt > 0) chk({tag, " p0"}, 8'(alloc_p0), 8'(e0));
        if (cnt > 1) chk({tag, " p1"}, 8'(alloc_p1), 8'(e1));
        if (cnt > 2) chk({tag, " p2"}, 8'(alloc_p2), 8'(e2));
        if (cnt > 3) chk({tag, " p3"}, 8'(alloc_p3), 8'(e3));
    endtask

    task automatic idle_inputs();
        alloc_count = 3'd0;
        free_en     = 4'd0;
        free_p0     = 6'd0;
        free_p1     = 6'd0;
        free_p2     = 6'd0;
        free_p3     = 6'd0;
    endtask

    initial begin
        // Drain 32 tags in groups of four, then underflow on the empty list.
        for (int k = 1; k <= 8; k++) begin
            add(4, 0, 0, 0, 0, 0, 1, 32 - 4 * k, 0, 0,
                32 + 4 * k, 33 + 4 * k, 34 + 4 * k, 35 + 4 * k);
        end
        add(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // Sparse free into an empty list with a same-cycle alloc that must not bypass.
        add(1, 4'b1010, 50, 7, 51, 9, 0, 2, 1, 0, 7, 9, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 7, 9, 0, 0);
        add(2, 4'b1111, 10, 11, 12, 13, 1, 4, 0, 0, 10, 11, 12, 13);
        // Steady alloc 4 / free 4 walks tail up to index 30.
        for (int j = 1; j <= 6; j++) begin
            add(4, 4'b1111, 10 + 4 * j, 11 + 4 * j, 12 + 4 * j, 13 + 4 * j, 1, 4, 0, 0,
                10 + 4 * j, 11 + 4 * j, 12 + 4 * j, 13 + 4 * j);
        end
        add(3, 0, 0, 0, 0, 0, 1, 1, 0, 0, 37, 0, 0, 0);
        // count=1: pop one and push four with tail crossing 31 -> 0.
        add(1, 4'b1111, 40, 41, 42, 43, 1, 4, 0, 0, 40, 41, 42, 43);
        for (int j = 0; j < 7; j++) begin
            add(0, 4'b1111, (44 + 4 * j) % 64, (45 + 4 * j) % 64, (46 + 4 * j) % 64,
                (47 + 4 * j) % 64, 1, 8 + 4 * j, 0, 0, 40, 41, 42, 43);
        end
        // Full: lone free overflows; the same free with a pop fits.
        add(0, 4'b0001, 60, 0, 0, 0, 1, 32, 0, 1, 40, 41, 42, 43);
        add(1, 4'b0001, 61, 0, 0, 0, 1, 32, 0, 0, 41, 42, 43, 44);
        add(5, 0, 0, 0, 0, 0, 1, 32, 1, 0, 41, 42, 43, 44);
        add(0, 0, 0, 0, 0, 0, 1, 32, 0, 0, 41, 42, 43, 44);

        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset ok", 8'(alloc_ok), 8'd1);
        chk_state("reset", 32, 0, 0, 32, 33, 34, 35);

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("v%0d", i);
            alloc_count = 3'(vecs[i].ac);
            free_en     = 4'(vecs[i].en);
            free_p0     = 6'(vecs[i].f0);
            free_p1     = 6'(vecs[i].f1);
            free_p2     = 6'(vecs[i].f2);
            free_p3     = 6'(vecs[i].f3);
            #1;
            chk({tag, " ok"}, 8'(alloc_ok), 8'(vecs[i].ok));
            @(posedge clk);
            #1;
            chk_state(tag, vecs[i].cnt, vecs[i].uf, vecs[i].of,
                      vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3);
        end

        // Arm an underflow pulse, then reset mid-burst with alloc and free both active.
        alloc_count = 3'd5;
        @(posedge clk);
        #1;
        chk("pre-rst underflow", 8'(underflow), 8'd1);
        rst         = 1'b1;
        alloc_count = 3'd4;
        free_en     = 4'b1111;
        free_p0     = 6'd20;
        free_p1     = 6'd21;
        free_p2     = 6'd22;
        free_p3     = 6'd23;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        #1;
        chk_state("midrst", 32, 0, 0, 32, 33, 34, 35);
        chk("midrst ok", 8'(alloc_ok), 8'd1);
        alloc_count = 3'd2;
        @(posedge clk);
        #1;
        chk_state("post-rst", 30, 0, 0, 34, 35, 36, 37);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
